// File: rtl/ppu_timing_controller.sv
// PPU master sequencer: dot/line counters, mode FSM, CPU access locks,
// LYC compare and VBlank/STAT interrupt request generation.
module ppu_timing_controller #(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154,
  parameter int DRAW_MAX_DOTS = 289
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tclk_in,
  input  logic       lcd_en_in,
  input  logic [3:0] stat_sel_in,
  input  logic [7:0] lyc_in,
  input  logic       draw_done_in,
  output logic [1:0] mode_out,
  output logic [7:0] ly_out,
  output logic [8:0] dot_out,
  output logic       lyc_eq_out,
  output logic       oam_scan_start_out,
  output logic       draw_start_out,
  output logic       draw_timeout_out,
  output logic       oam_lock_out,
  output logic       vram_lock_out,
  output logic       vblank_irq_out,
  output logic       stat_irq_out
);

  localparam logic [1:0] M_HBLANK = 2'd0;
  localparam logic [1:0] M_VBLANK = 2'd1;
  localparam logic [1:0] M_OAM    = 2'd2;
  localparam logic [1:0] M_DRAW   = 2'd3;

  localparam logic [8:0] L_DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] L_OAM_LAST  = 9'(OAM_DOTS - 1);
  localparam logic [8:0] L_DRAW_LAST = 9'(OAM_DOTS + DRAW_MAX_DOTS - 1);
  localparam logic [7:0] L_LY_LAST   = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] L_VIS       = 8'(VISIBLE_LINES);

  logic [8:0] r_dot;
  logic [7:0] r_ly;
  logic [1:0] r_mode;
  logic       r_disabled;
  logic       r_lyc_eq;
  logic       r_stat_line;
  logic       r_stat_irq;
  logic       r_scan_start;
  logic       r_draw_start;
  logic       r_timeout;
  logic       r_vblank;
  logic       r_oam_lock;
  logic       r_vram_lock;

  logic       w_eol;
  logic [7:0] w_ly_nxt;
  logic [1:0] w_mode_nxt;
  logic       w_scan;
  logic       w_draw;
  logic       w_tmo;
  logic       w_vbl;
  logic       w_stat;

  assign w_eol    = (r_dot == L_DOT_LAST);
  assign w_ly_nxt = (r_ly == L_LY_LAST) ? 8'd0 : r_ly + 8'd1;

  always_comb begin
    w_mode_nxt = r_mode;
    w_scan     = 1'b0;
    w_draw     = 1'b0;
    w_tmo      = 1'b0;
    w_vbl      = 1'b0;
    unique case (r_mode)
      M_OAM: begin
        if (r_dot == L_OAM_LAST) begin
          w_mode_nxt = M_DRAW;
          w_draw     = 1'b1;
        end
      end
      M_DRAW: begin
        // done has priority over the timeout on the same dot
        if (draw_done_in) begin
          w_mode_nxt = M_HBLANK;
        end else if (r_dot == L_DRAW_LAST) begin
          w_mode_nxt = M_HBLANK;
          w_tmo      = 1'b1;
        end
      end
      M_HBLANK: begin
        if (w_eol) begin
          if (w_ly_nxt < L_VIS) begin
            w_mode_nxt = M_OAM;
            w_scan     = 1'b1;
          end else begin
            w_mode_nxt = M_VBLANK;
            w_vbl      = 1'b1;
          end
        end
      end
      M_VBLANK: begin
        if (w_eol && (r_ly == L_LY_LAST)) begin
          w_mode_nxt = M_OAM;
          w_scan     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_stat = ~r_disabled & (
    (stat_sel_in[3] & r_lyc_eq) |
    (stat_sel_in[2] & (r_mode == M_OAM)) |
    (stat_sel_in[1] & (r_mode == M_VBLANK)) |
    (stat_sel_in[0] & (r_mode == M_HBLANK)));

  always_ff @(posedge clk_in) begin
    if (rst_in || !lcd_en_in) begin
      r_dot        <= '0;
      r_ly         <= '0;
      r_mode       <= M_HBLANK;
      r_disabled   <= 1'b1;
      r_lyc_eq     <= 1'b0;
      r_stat_line  <= 1'b0;
      r_stat_irq   <= 1'b0;
      r_scan_start <= 1'b0;
      r_draw_start <= 1'b0;
      r_timeout    <= 1'b0;
      r_vblank     <= 1'b0;
      r_oam_lock   <= 1'b0;
      r_vram_lock  <= 1'b0;
    end else begin
      r_lyc_eq     <= (r_ly == lyc_in);
      r_stat_line  <= w_stat;
      r_stat_irq   <= w_stat & ~r_stat_line;
      r_scan_start <= 1'b0;
      r_draw_start <= 1'b0;
      r_timeout    <= 1'b0;
      r_vblank     <= 1'b0;
      if (tclk_in) begin
        if (r_disabled) begin
          r_disabled   <= 1'b0;
          r_dot        <= '0;
          r_ly         <= '0;
          r_mode       <= M_OAM;
          r_oam_lock   <= 1'b1;
          r_vram_lock  <= 1'b0;
          r_scan_start <= 1'b1;
        end else begin
          if (w_eol) begin
            r_dot <= '0;
            r_ly  <= w_ly_nxt;
          end else begin
            r_dot <= r_dot + 9'd1;
          end
          r_mode       <= w_mode_nxt;
          r_oam_lock   <= (w_mode_nxt == M_OAM) || (w_mode_nxt == M_DRAW);
          r_vram_lock  <= (w_mode_nxt == M_DRAW);
          r_scan_start <= w_scan;
          r_draw_start <= w_draw;
          r_timeout    <= w_tmo;
          r_vblank     <= w_vbl;
        end
      end
    end
  end

  assign mode_out           = r_mode;
  assign ly_out             = r_ly;
  assign dot_out            = r_dot;
  assign lyc_eq_out         = r_lyc_eq;
  assign oam_scan_start_out = r_scan_start;
  assign draw_start_out     = r_draw_start;
  assign draw_timeout_out   = r_timeout;
  assign oam_lock_out       = r_oam_lock;
  assign vram_lock_out      = r_vram_lock;
  assign vblank_irq_out     = r_vblank;
  assign stat_irq_out       = r_stat_irq;

endmodule

// File: tb/tb_ppu_timing_controller.sv
// Directed bench for ppu_timing_controller: line timing, frame,
// LYC/STAT interrupts, disable and reset behaviour.
module tb_ppu_timing_controller;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tclk_in;
  logic       lcd_en_in;
  logic [3:0] stat_sel_in;
  logic [7:0] lyc_in;
  logic       draw_done_in;
  logic [1:0] mode_out;
  logic [7:0] ly_out;
  logic [8:0] dot_out;
  logic       lyc_eq_out;
  logic       oam_scan_start_out;
  logic       draw_start_out;
  logic       draw_timeout_out;
  logic       oam_lock_out;
  logic       vram_lock_out;
  logic       vblank_irq_out;
  logic       stat_irq_out;

  int n_cmp = 0;
  int n_bad = 0;

  ppu_timing_controller dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .tclk_in            (tclk_in),
    .lcd_en_in          (lcd_en_in),
    .stat_sel_in        (stat_sel_in),
    .lyc_in             (lyc_in),
    .draw_done_in       (draw_done_in),
    .mode_out           (mode_out),
    .ly_out             (ly_out),
    .dot_out            (dot_out),
    .lyc_eq_out         (lyc_eq_out),
    .oam_scan_start_out (oam_scan_start_out),
    .draw_start_out     (draw_start_out),
    .draw_timeout_out   (draw_timeout_out),
    .oam_lock_out       (oam_lock_out),
    .vram_lock_out      (vram_lock_out),
    .vblank_irq_out     (vblank_irq_out),
    .stat_irq_out       (stat_irq_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_mode"}, mode_out, 0);
    chk({tag, "_ly"}, ly_out, 0);
    chk({tag, "_dot"}, dot_out, 0);
    chk({tag, "_oaml"}, oam_lock_out, 0);
    chk({tag, "_vraml"}, vram_lock_out, 0);
    chk({tag, "_lyceq"}, lyc_eq_out, 0);
    chk({tag, "_pulses"},
        {oam_scan_start_out, draw_start_out, draw_timeout_out,
         vblank_irq_out, stat_irq_out}, 0);
  endtask

  int exp_sl[4] = '{5, 6, 6, 7};
  int exp_sd[4] = '{2, 1, 370, 370};

  initial begin
    int ns;
    int nvb;
    int em;
    rst_in       = 1'b1;
    tclk_in      = 1'b1;
    lcd_en_in    = 1'b0;
    stat_sel_in  = 4'd0;
    lyc_in       = 8'd0;
    draw_done_in = 1'b0;
    repeat (3) step();
    chk_off("rst");

    // enable tick
    rst_in    = 1'b0;
    lcd_en_in = 1'b1;
    step();

    // line 0: draw done presented at dot 251
    for (int d = 0; d < 456; d++) begin
      em = (d < 80) ? 2 : (d < 252) ? 3 : 0;
      chk("l0_ly", ly_out, 0);
      chk("l0_dot", dot_out, d);
      chk("l0_mode", mode_out, em);
      chk("l0_oaml", oam_lock_out, int'(d < 252));
      chk("l0_vraml", vram_lock_out, int'(d >= 80 && d < 252));
      chk("l0_dstart", draw_start_out, int'(d == 80));
      chk("l0_sstart", oam_scan_start_out, int'(d == 0));
      chk("l0_tmo", draw_timeout_out, 0);
      draw_done_in = (d == 251);
      step();
      draw_done_in = 1'b0;
    end

    // line 1: no done, timeout ends draw
    for (int d = 0; d < 456; d++) begin
      em = (d < 80) ? 2 : (d < 369) ? 3 : 0;
      chk("l1_ly", ly_out, 1);
      chk("l1_mode", mode_out, em);
      chk("l1_tmo", draw_timeout_out, int'(d == 369));
      chk("l1_oaml", oam_lock_out, int'(d < 369));
      chk("l1_vraml", vram_lock_out, int'(d >= 80 && d < 369));
      chk("l1_sstart", oam_scan_start_out, int'(d == 0));
      step();
    end

    // run to line 60 dot 200 (mid-draw) and disable
    for (int k = 0; k < 60 * 456 + 200 - 912; k++) step();
    chk("pre_off_ly", ly_out, 60);
    chk("pre_off_dot", dot_out, 200);
    chk("pre_off_mode", mode_out, 3);
    lcd_en_in   = 1'b0;
    lyc_in      = 8'd5;
    stat_sel_in = 4'b1000;
    step();
    chk_off("off");
    step();
    chk_off("off2");
    lcd_en_in = 1'b1;
    step();
    chk("reen_mode", mode_out, 2);
    chk("reen_ly", ly_out, 0);
    chk("reen_dot", dot_out, 0);
    chk("reen_sstart", oam_scan_start_out, 1);
    chk("reen_oaml", oam_lock_out, 1);

    // full frame from the enable point
    ns  = 0;
    nvb = 0;
    for (int n = 0; n < 70224; n++) begin
      int ln;
      int d;
      ln = n / 456;
      d  = n % 456;
      if (d == 0) begin
        chk("fr_ly", ly_out, ln);
        chk("fr_dot", dot_out, 0);
        chk("fr_mode", mode_out, (ln < 144) ? 2 : 1);
        chk("fr_sstart", oam_scan_start_out, int'(ln < 144));
      end
      if (n == 70223) begin
        chk("fr_last_ly", ly_out, 153);
        chk("fr_last_dot", dot_out, 455);
        chk("fr_last_mode", mode_out, 1);
      end
      if (ln == 143 && d == 455) chk("l143_mode", mode_out, 0);
      if (ln == 5 && d == 100) chk("lyc_eq5", lyc_eq_out, 1);
      if (ln == 5 && d == 101) chk("lyc_drop", lyc_eq_out, 0);
      if (ln == 8 && d == 41) chk("done_ign", mode_out, 2);
      if (vblank_irq_out) begin
        nvb++;
        chk("vbl_pos", n, 144 * 456);
      end
      if (stat_irq_out) begin
        if (ns < 4) begin
          chk("stat_ly", ln, exp_sl[ns]);
          chk("stat_dot", d, exp_sd[ns]);
        end
        ns++;
      end
      if (ln == 5 && d == 100) lyc_in = 8'd7;
      if (ln == 6 && d == 0) stat_sel_in = 4'b0101;
      if (ln == 8 && d == 0) stat_sel_in = 4'b0000;
      draw_done_in = (ln == 8 && d == 40);
      step();
    end
    draw_done_in = 1'b0;
    chk("wrap_ly", ly_out, 0);
    chk("wrap_dot", dot_out, 0);
    chk("wrap_mode", mode_out, 2);
    chk("wrap_sstart", oam_scan_start_out, 1);
    chk("vbl_count", nvb, 1);
    chk("stat_count", ns, 4);

    // synchronous reset mid-line
    repeat (100) step();
    chk("pre_rst_dot", dot_out, 100);
    chk("pre_rst_mode", mode_out, 3);
    rst_in = 1'b1;
    step();
    chk_off("mrst");
    rst_in = 1'b0;
    step();
    chk("rst_reen_mode", mode_out, 2);
    chk("rst_reen_dot", dot_out, 0);
    chk("rst_reen_sstart", oam_scan_start_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
